// File: rtl/mc_pkg.sv
// Shared constants for the multi-cycle MIPS main controller and ALU control.
// Holds state encodings, opcode/funct values, ALUOp classes and mux codes.
package mc_pkg;

    // Register index written by JAL; exported for the datapath.
    localparam logic [4:0] LINK_REG = 5'd31;

    typedef enum logic [3:0] {
        S_IF      = 4'd0,
        S_ID      = 4'd1,
        S_MEM_ADR = 4'd2,
        S_MEM_RD  = 4'd3,
        S_WB_MEM  = 4'd4,
        S_MEM_WR  = 4'd5,
        S_EX_R    = 4'd6,
        S_WB_R    = 4'd7,
        S_EX_I    = 4'd8,
        S_WB_I    = 4'd9,
        S_EX_BR   = 4'd10,
        S_EX_J    = 4'd11,
        S_EX_JAL  = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_SLT  = 6'h2A;

    localparam logic [1:0] ALUOP_ADD = 2'b00;
    localparam logic [1:0] ALUOP_SUB = 2'b01;
    localparam logic [1:0] ALUOP_R   = 2'b10;
    localparam logic [1:0] ALUOP_I   = 2'b11;

    localparam logic [1:0] DST_RT   = 2'b00;
    localparam logic [1:0] DST_RD   = 2'b01;
    localparam logic [1:0] DST_LINK = 2'b10;

    localparam logic [1:0] M2R_ALU = 2'b00;
    localparam logic [1:0] M2R_MDR = 2'b01;
    localparam logic [1:0] M2R_PC  = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_A     = 2'b01;
    localparam logic [1:0] SRCA_SHAMT = 2'b10;

    localparam logic [1:0] SRCB_B     = 2'b00;
    localparam logic [1:0] SRCB_4     = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PCS_ALU  = 2'b00;
    localparam logic [1:0] PCS_OUT  = 2'b01;
    localparam logic [1:0] PCS_JUMP = 2'b10;
    localparam logic [1:0] PCS_RS   = 2'b11;

endpackage

// File: rtl/mc_main_ctrl.sv
// Main control FSM of the multi-cycle MIPS core: sequences IF/ID/EX/MEM/WB,
// drives all datapath enables and mux selects, owns the shared memory port.
// Ports: clk, rst (async, high); op, func, zero, mem_ready in; pc_en, iord,
// mem_read, mem_write, ir_write, reg_write, reg_dst, mem_to_reg, alu_src_a,
// alu_src_b, alu_op, alu_func, pc_source, illegal_op out.
// Optional MC_MAIN_CTRL_PERF_EN adds cycle_cnt and inst_cnt (32-bit) outputs.
module mc_main_ctrl
    import mc_pkg::*;
#(
    parameter logic [3:0] RESET_STATE = 4'd0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] op,
    input  logic [5:0] func,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_en,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic [1:0] reg_dst,
    output logic [1:0] mem_to_reg,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [5:0] alu_func,
`ifdef MC_MAIN_CTRL_PERF_EN
    output logic [31:0] cycle_cnt,
    output logic [31:0] inst_cnt,
`endif
    output logic [1:0] pc_source,
    output logic       illegal_op
);

    state_t state, next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= state_t'(RESET_STATE);
        else     state <= next;
    end

    always_comb begin
        next       = state;
        pc_en      = 1'b0;
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = DST_RT;
        mem_to_reg = M2R_ALU;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_B;
        alu_op     = ALUOP_ADD;
        pc_source  = PCS_ALU;
        illegal_op = 1'b0;
        case (state)
            S_IF: begin
                mem_read  = 1'b1;
                alu_src_b = SRCB_4;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_en    = 1'b1;
                    next     = S_ID;
                end
            end
            S_ID: begin
                // Speculatively form the branch target into ALUOut.
                alu_src_b = SRCB_IMMSH;
                case (op)
                    OP_LW, OP_SW:   next = S_MEM_ADR;
                    OP_RTYPE:       next = S_EX_R;
                    OP_BEQ, OP_BNE: next = S_EX_BR;
                    OP_J:           next = S_EX_J;
                    OP_JAL:         next = S_EX_JAL;
                    OP_ADDIU, OP_SLTI,
                    OP_SLTIU, OP_LUI: next = S_EX_I;
                    default: begin
                        illegal_op = 1'b1;
                        next       = S_IF;
                    end
                endcase
            end
            S_MEM_ADR: begin
                alu_src_a = SRCA_A;
                alu_src_b = SRCB_IMM;
                next = (op == OP_LW) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
                if (mem_ready) next = S_WB_MEM;
            end
            S_WB_MEM: begin
                reg_write  = 1'b1;
                mem_to_reg = M2R_MDR;
                next       = S_IF;
            end
            S_MEM_WR: begin
                mem_write = 1'b1;
                iord      = 1'b1;
                if (mem_ready) next = S_IF;
            end
            S_EX_R: begin
                alu_op    = ALUOP_R;
                alu_src_a = (func == FN_SLL) ? SRCA_SHAMT : SRCA_A;
                case (func)
                    FN_JR: begin
                        pc_en     = 1'b1;
                        pc_source = PCS_RS;
                        next      = S_IF;
                    end
                    FN_SLL, FN_ADDU, FN_OR, FN_SLT: next = S_WB_R;
                    default: begin
                        illegal_op = 1'b1;
                        next       = S_IF;
                    end
                endcase
            end
            S_WB_R: begin
                reg_write = 1'b1;
                reg_dst   = DST_RD;
                next      = S_IF;
            end
            S_EX_I: begin
                alu_op    = ALUOP_I;
                alu_src_a = SRCA_A;
                alu_src_b = SRCB_IMM;
                next      = S_WB_I;
            end
            S_WB_I: begin
                reg_write = 1'b1;
                next      = S_IF;
            end
            S_EX_BR: begin
                alu_op    = ALUOP_SUB;
                alu_src_a = SRCA_A;
                pc_source = PCS_OUT;
                pc_en     = (op == OP_BNE) ? !zero : zero;
                next      = S_IF;
            end
            S_EX_J: begin
                pc_en     = 1'b1;
                pc_source = PCS_JUMP;
                next      = S_IF;
            end
            S_EX_JAL: begin
                // PC still holds PC+4 here, so it is the link value.
                pc_en      = 1'b1;
                pc_source  = PCS_JUMP;
                reg_write  = 1'b1;
                reg_dst    = DST_LINK;
                mem_to_reg = M2R_PC;
                next       = S_IF;
            end
            default: next = S_IF;
        endcase
    end

    always_comb begin
        case (alu_op)
            ALUOP_R: alu_func = func;
            ALUOP_I: alu_func = op;
            default: alu_func = 6'd0;
        endcase
    end

`ifdef MC_MAIN_CTRL_PERF_EN
    // An instruction retires on any return to IF except an illegal abort.
    logic retire;
    assign retire = (state != S_IF) && (next == S_IF) && !illegal_op;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_cnt <= 32'd0;
            inst_cnt  <= 32'd0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
            if (retire) inst_cnt <= inst_cnt + 32'd1;
        end
    end
`endif

endmodule
